// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT sequencing for the 32-bit datapath.
// Optional performance counters (cycle_cnt, instr_cnt) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_unit #(
    parameter int unsigned         OP_W    = 6,
    parameter int unsigned         FN_W    = 5,
    parameter logic [OP_W-1:0]     HALT_OP = 6'h3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] func,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic [FN_W-1:0] alu_op,
    output logic            illegal,
    output logic            halted
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [FN_W-1:0] fn_q;
    logic            dec_halt, dec_legal;

    assign dec_halt  = (opcode == HALT_OP);
    assign dec_legal = (opcode < OP_W'(6));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (dec_halt)       state_d = StHalt;
                else if (dec_legal) state_d = StExec;
                else                state_d = StFetch;
            end
            StExec: begin
                if (op_q == OP_W'(0) || op_q == OP_W'(1))      state_d = StWb;
                else if (op_q == OP_W'(2) || op_q == OP_W'(3)) state_d = StMem;
                else                                           state_d = StFetch;
            end
            StMem:    if (mem_ready) state_d = (op_q == OP_W'(2)) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q <= opcode;
                fn_q <= func;
            end
        end
    end

    // Outputs are forced low while rst is high so a pending memory write cannot survive reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        illegal    = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StDecode: illegal = !dec_halt && !dec_legal;
                StExec: begin
                    if (op_q == OP_W'(0)) begin
                        alu_op = fn_q;
                    end else if (op_q == OP_W'(1)) begin
                        alu_op  = fn_q;
                        alu_src = 1'b1;
                    end else if (op_q == OP_W'(2) || op_q == OP_W'(3)) begin
                        alu_src = 1'b1;
                    end else if (op_q == OP_W'(4)) begin
                        alu_op   = FN_W'(1);
                        pc_write = alu_zero;
                        pc_src   = 2'd1;
                    end else begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                end
                StMem: begin
                    mem_req = 1'b1;
                    mem_we  = (op_q == OP_W'(3));
                end
                StWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_W'(2));
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // Only completions out of EXEC/MEM/WB retire; illegal skips leave from DECODE.
    assign retire = (state_d == StFetch) &&
                    (state_q == StExec || state_q == StMem || state_q == StWb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != StHalt) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle FSM that sequences the 32-bit processor datapath: instruction fetch, decode, execute, memory and writeback.
- Consumes opcode/func from the instruction decoder plus ALU zero and memory ready.
- Drives register-file, PC, IR, ALU and memory-interface control strobes.
- Sits between instruction_decode and the datapath muxes/enables.

Parameters:
- OP_W, 6, opcode width
- FN_W, 5, func width
- HALT_OP, 6'h3F, opcode that stops the machine

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  from instruction_decode; valid from DECODE onward
- func  in  5  from instruction_decode; ALU function for R-type
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (store), 0 = read
- ir_write  out  1  load IR with fetched word
- pc_write  out  1  PC <- next PC / target
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback data from memory
- alu_src  out  1  0 = rt, 1 = sign-extended imm
- alu_op  out  5  ALU function code
- illegal  out  1  one-cycle pulse on unknown opcode
- halted  out  1  machine stopped

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is an implementation choice.
- Reset (async, any state): state = FETCH. All outputs 0, except mem_req = 1 the cycle after reset deassertion.
- Opcode classes: 0 = R-type ALU, 1 = ALU-imm, 2 = load, 3 = store, 4 = branch-if-zero, 5 = jump, HALT_OP = halt. Any other value is illegal.
- FETCH: mem_req = 1, mem_we = 0. Hold the state while mem_ready = 0.
  - On mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, next state DECODE.
- DECODE: latch opcode/func into internal registers; all strobes 0.
  - Halt -> HALT.
  - Illegal -> illegal = 1 for this cycle, then FETCH. PC is already advanced, so the instruction is skipped.
  - Otherwise -> EXEC.
- EXEC: alu_op output values are:
  - R-type: func.
  - ALU-imm: func with alu_src = 1.
  - Load/store: add code 5'd0 with alu_src = 1.
  - Branch: subtract code 5'd1.
- EXEC transitions:
  - R-type and ALU-imm -> WB.
  - Load and store -> MEM.
  - Branch: pc_write = alu_zero, pc_src = 1, then FETCH.
  - Jump: pc_write = 1, pc_src = 2, then FETCH.
- MEM: mem_req = 1 and mem_we = 1 for store, 0 for load. Hold while mem_ready = 0.
  - On ready: load -> WB; store -> FETCH.
- WB: reg_write = 1 for exactly one cycle; mem_to_reg = 1 for load only. Next state FETCH.
- HALT: terminal; halted = 1, all other strobes 0. Left only by rst.
- Latencies with zero wait states, FETCH to next FETCH:
  - R-type and ALU-imm: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and jump: 3 cycles.
  - Illegal: 2 cycles.
- Each mem_ready = 0 cycle adds one cycle in FETCH/MEM.
- mem_ready outside FETCH/MEM is ignored.
- Changes on the opcode/func inputs after DECODE have no effect, because the latched copies are used.
- Reset asserted mid-MEM drops mem_req immediately, so no write strobe survives reset.
- Outputs are combinational from state and latched opcode. The only Mealy terms are FETCH/MEM advance on mem_ready and pc_write on alu_zero.

Optional Feature:
- Macro CTRL_PERF_CNT_EN. When defined, the block adds two 32-bit outputs:
  - cycle_cnt: increments every cycle while not halted.
  - instr_cnt: increments on each transition into FETCH from EXEC, MEM or WB (retired instructions; illegal skips are not counted).
  - Both are cleared by rst and wrap modulo 2^32.
- When undefined: neither port nor the counter logic exists. Behaviour is otherwise identical.

Test Plan:
- R-type, opcode 0, func 5'd3, mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB. alu_op = 3 in EXEC; reg_write high for one cycle in cycle 4; next FETCH in cycle 5.
- Load, opcode 2, with mem_ready low for 2 cycles in MEM -> mem_req high 3 cycles with mem_we = 0. WB has reg_write = 1 and mem_to_reg = 1; total 7 cycles.
- Store, opcode 3 -> MEM asserts mem_req = 1 and mem_we = 1; reg_write never asserted; returns to FETCH after mem_ready.
- Branch, opcode 4, alu_zero = 1 then repeated with alu_zero = 0 -> pc_write = 1 with pc_src = 1 in the first case; pc_write = 0 in the second.
- Opcode 6'h2A -> illegal pulses for one cycle in DECODE, then FETCH. Opcode 6'h3F -> halted = 1 and stays there; rst returns to FETCH.
- rst asserted mid-MEM of a store -> mem_req and mem_we drop within the same cycle. Under CTRL_PERF_CNT_EN, both counters read 0.
